// File: rtl/uplink_rx.sv
// Uplink receiver: buffers UPLINK-ONE/ZERO strobes, issues SHANC/SHINC counter requests, raises UPRUPT per word.
// Optional partial-word idle timeout is compiled in with `define UPLINK_TIMEOUT_EN.
module uplink_rx #(
    parameter int WORD_BITS   = 15,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           up_one,
    input  logic                           up_zero,
    input  logic                           up_block,
    output logic                           cnt_req,
    output logic                           cnt_shanc,
    input  logic                           cnt_ack,
    output logic                           uprupt_req,
    input  logic                           uprupt_ack,
    output logic [$clog2(WORD_BITS+1)-1:0] bit_cnt,
    output logic                           overflow,
    output logic                           frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(WORD_BITS+1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS-1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 || TIMEOUT_CYC < 1 || WORD_BITS < 1) begin : g_bad_params
        $error("uplink_rx: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYC and WORD_BITS >= 1");
    end

    logic            r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_cnt_req;
    logic            r_shanc;
    logic            r_uprupt;
    logic [BW-1:0]   r_bit_cnt;
    logic            r_overflow;
    logic            r_frame_err;

    logic            w_accept;
    logic            w_illegal;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic [AW:0]     w_cnt_after_pop;
    logic [AW:0]     w_cnt_next;
    logic [AW-1:0]   w_rd_next;
    logic            w_word_done;
    logic            w_timeout;

    assign w_accept        = !up_block && (up_one ^ up_zero);
    assign w_illegal       = !up_block && up_one && up_zero;
    assign w_pop           = r_cnt_req && cnt_ack;
    assign w_full          = (r_count == CNT_FULL);
    assign w_push          = w_accept && (!w_full || w_pop);
    assign w_drop          = w_accept && w_full && !w_pop;
    assign w_cnt_after_pop = r_count - {{AW{1'b0}}, w_pop};
    assign w_cnt_next      = w_cnt_after_pop + {{AW{1'b0}}, w_push};
    assign w_rd_next       = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    assign w_word_done     = w_pop && (r_bit_cnt == LAST_BIT);

`ifdef UPLINK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC+1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC-1);

    logic [TW-1:0] r_idle;
    logic          w_idle_run;

    assign w_idle_run = (r_count == '0) && !r_cnt_req && (r_bit_cnt != '0);
    assign w_timeout  = !w_accept && w_idle_run && (r_idle == IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (w_accept || !w_idle_run || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Storage holds data only; validity is tracked by the reset pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= up_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_cnt_next;
        end
    end

    // A bit pushed this edge is excluded so a request appears one edge after the push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_req <= 1'b0;
            r_shanc   <= 1'b0;
        end else begin
            r_cnt_req <= (w_cnt_after_pop != '0);
            r_shanc   <= r_mem[w_rd_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_uprupt    <= 1'b0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_timeout || w_word_done) begin
                r_bit_cnt <= '0;
            end else if (w_pop) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_word_done) begin
                r_uprupt <= 1'b1;
            end else if (uprupt_ack) begin
                r_uprupt <= 1'b0;
            end

            // A fresh cause in the ack cycle keeps the flag set.
            if (w_drop || (w_word_done && r_uprupt)) begin
                r_overflow <= 1'b1;
            end else if (uprupt_ack) begin
                r_overflow <= 1'b0;
            end

            r_frame_err <= w_illegal || w_timeout;
        end
    end

    assign cnt_req    = r_cnt_req;
    assign cnt_shanc  = r_shanc;
    assign uprupt_req = r_uprupt;
    assign bit_cnt    = r_bit_cnt;
    assign overflow   = r_overflow;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uplink_rx.sv
// Testbench for uplink_rx: directed vector table, hand sequences and randomized traffic vs. a queue-based model.
module tb_uplink_rx;

    localparam int WB = 15;
    localparam int D  = 4;
`ifdef UPLINK_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif
    localparam int BW = $clog2(WB+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          one = 1'b0, zero = 1'b0, blk = 1'b0, ack = 1'b0, uack = 1'b0;
    logic          cnt_req, cnt_shanc, uprupt_req, overflow, frame_err;
    logic [BW-1:0] bit_cnt;

    uplink_rx #(.WORD_BITS(WB), .FIFO_DEPTH(D), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .up_one(one), .up_zero(zero), .up_block(blk),
        .cnt_req(cnt_req), .cnt_shanc(cnt_shanc), .cnt_ack(ack),
        .uprupt_req(uprupt_req), .uprupt_ack(uack),
        .bit_cnt(bit_cnt), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: pending bits with the edge index at which they were accepted.
    typedef struct { logic b; int t; } ent_t;
    ent_t q[$];
    int   now;
    logic m_req, m_shanc, m_up, m_ovf, m_ferr;
    int   m_bc, m_idle;
    int   hs;
    logic hs_bits[$];
    int   ferr_seen;

    typedef struct {
        logic one, zero, blk, ack, uack;
        logic req, shanc, ferr, ovf, up;
        int   bc;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        now = 0; m_req = 0; m_shanc = 0; m_up = 0; m_ovf = 0; m_ferr = 0;
        m_bc = 0; m_idle = 0;
    endtask

    task automatic model_edge();
        logic acc, pop, done, drop;
        int   n;
        now++;
        pop  = m_req && ack;
        acc  = !blk && (one ^ zero);
        n    = q.size();
        done = 0;
        drop = 0;
        m_ferr = !blk && one && zero;
`ifdef UPLINK_TIMEOUT_EN
        if (acc) m_idle = 0;
        else if (n == 0 && !m_req && m_bc != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_idle = 0; m_bc = 0; m_ferr = 1;
            end
        end else m_idle = 0;
`endif
        if (pop) begin
            void'(q.pop_front());
            m_bc++;
            if (m_bc == WB) begin
                m_bc = 0; done = 1;
            end
        end
        if (acc) begin
            if (n == D && !pop) drop = 1;
            else q.push_back('{one, now});
        end
        if (drop || (done && m_up)) m_ovf = 1;
        else if (uack) m_ovf = 0;
        if (done) m_up = 1;
        else if (uack) m_up = 0;
        m_req = (q.size() > 0) && (q[0].t < now);
        if (m_req) m_shanc = q[0].b;
    endtask

    task automatic cyc();
        if (cnt_req && ack) begin
            hs++;
            hs_bits.push_back(cnt_shanc);
        end
        model_edge();
        @(posedge clk);
        #1;
        if (frame_err) ferr_seen++;
        chk("cnt_req", cnt_req, m_req);
        if (m_req) chk("cnt_shanc", cnt_shanc, m_shanc);
        chk("uprupt_req", uprupt_req, m_up);
        chk("overflow", overflow, m_ovf);
        chk("frame_err", frame_err, m_ferr);
        chk("bit_cnt", bit_cnt, m_bc);
    endtask

    task automatic set_in(input logic o, input logic z, input logic b, input logic a, input logic u);
        one = o; zero = z; blk = b; ack = a; uack = u;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        hs = 0;
        hs_bits.delete();
        ferr_seen = 0;
    endtask

    task automatic add(input logic o, z, b, a, u, input logic req, sh, fe, ov, up, input int bc);
        vec_t v;
        v.one = o; v.zero = z; v.blk = b; v.ack = a; v.uack = u;
        v.req = req; v.shanc = sh; v.ferr = fe; v.ovf = ov; v.up = up; v.bc = bc;
        vt.push_back(v);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p;
        int r;

        // Directed vector table (inputs before edge, outputs after edge)
        add(1,0,0,0,0, 0,0,0,0,0, 0);
        add(0,0,0,0,0, 1,1,0,0,0, 0);
        add(0,0,0,1,0, 0,0,0,0,0, 1);
        add(1,1,0,0,0, 0,0,1,0,0, 1);
        add(0,0,0,0,0, 0,0,0,0,0, 1);
        add(1,0,1,0,0, 0,0,0,0,0, 1);
        add(0,1,1,0,0, 0,0,0,0,0, 1);
        add(1,1,1,0,0, 0,0,0,0,0, 1);
        add(0,0,0,0,0, 0,0,0,0,0, 1);
        add(0,1,0,0,0, 0,0,0,0,0, 1);
        add(0,0,0,0,0, 1,0,0,0,0, 1);
        add(0,0,0,1,0, 0,0,0,0,0, 2);
        add(0,0,0,1,0, 0,0,0,0,0, 2);
        add(0,0,0,0,1, 0,0,0,0,0, 2);

        do_reset();
        chk("reset_req", cnt_req, 0);
        chk("reset_up", uprupt_req, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_ferr", frame_err, 0);
        chk("reset_bc", bit_cnt, 0);

        for (int i = 0; i < vt.size(); i++) begin
            set_in(vt[i].one, vt[i].zero, vt[i].blk, vt[i].ack, vt[i].uack);
            cyc();
            chk($sformatf("vec%0d_req", i), cnt_req, vt[i].req);
            if (vt[i].req) chk($sformatf("vec%0d_shanc", i), cnt_shanc, vt[i].shanc);
            chk($sformatf("vec%0d_ferr", i), frame_err, vt[i].ferr);
            chk($sformatf("vec%0d_ovf", i), overflow, vt[i].ovf);
            chk($sformatf("vec%0d_up", i), uprupt_req, vt[i].up);
            chk($sformatf("vec%0d_bc", i), bit_cnt, vt[i].bc);
        end

        // Asynchronous reset with three bits queued
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 0);
            cyc();
        end
        set_in(0, 0, 0, 0, 0);
        chk("prereset_req", cnt_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", cnt_req, 0);
        chk("async_rst_shanc", cnt_shanc, 0);
        chk("async_rst_up", uprupt_req, 0);
        chk("async_rst_ovf", overflow, 0);
        chk("async_rst_ferr", frame_err, 0);
        chk("async_rst_bc", bit_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) cyc();
        chk("post_rst_empty", cnt_req, 0);

        // One word of 0x5A5A, LSB first, acked every cycle
        do_reset();
        p = 16'h5A5A;
        for (int i = 0; i < WB; i++) begin
            set_in(p[i], !p[i], 0, 1, 0);
            cyc();
        end
        set_in(0, 0, 0, 1, 0);
        for (int i = 0; i < 8 && hs < WB; i++) cyc();
        chk("word_hs_count", hs, WB);
        for (int i = 0; i < WB && i < hs_bits.size(); i++)
            chk($sformatf("word_bit%0d", i), hs_bits[i], p[i]);
        chk("word_uprupt", uprupt_req, 1);
        chk("word_bc", bit_cnt, 0);
        chk("word_ovf", overflow, 0);

        // FIFO overrun: 6 strobes with no ack, then drain
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(logic'(i % 2), logic'(!(i % 2)), 0, 0, 0);
            cyc();
        end
        chk("ovr_ovf", overflow, 1);
        set_in(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc();
        chk("ovr_hs_count", hs, 4);
        for (int i = 0; i < 4 && i < hs_bits.size(); i++)
            chk($sformatf("ovr_bit%0d", i), hs_bits[i], i % 2);
        chk("ovr_bc", bit_cnt, 4);
        set_in(0, 0, 0, 0, 1);
        cyc();
        chk("ovr_cleared", overflow, 0);

        // Two words with the interrupt left pending
        do_reset();
        for (int i = 0; i < 2 * WB; i++) begin
            r = $urandom_range(0, 1);
            set_in(r[0], !r[0], 0, 1, 0);
            cyc();
        end
        set_in(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) cyc();
        chk("two_hs_count", hs, 2 * WB);
        chk("two_up", uprupt_req, 1);
        chk("two_ovf", overflow, 1);
        set_in(0, 0, 0, 0, 1);
        cyc();
        chk("two_ack_up", uprupt_req, 0);
        chk("two_ack_ovf", overflow, 0);

        // Partial word followed by a long idle stretch
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 1, 0);
            cyc();
        end
        set_in(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc();
        chk("partial_bc", bit_cnt, 5);
        set_in(0, 0, 0, 0, 0);
        ferr_seen = 0;
        for (int i = 0; i < 40; i++) cyc();
`ifdef UPLINK_TIMEOUT_EN
        chk("timeout_ferr_pulses", ferr_seen, 1);
        chk("timeout_bc", bit_cnt, 0);
`else
        chk("idle_ferr_pulses", ferr_seen, 0);
        chk("idle_bc", bit_cnt, 5);
`endif

        // Randomized traffic, busy ack phase then starved ack phase
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            one  = (r < 35) || (r >= 70 && r < 73);
            zero = (r >= 35 && r < 73);
            blk  = ($urandom_range(0, 19) == 0);
            ack  = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 3);
            uack = ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
